arp_resolver: RTL and testbench
===============================

// Module: arp_resolver
// PURPOSE
//  Next-hop MAC resolver that sits directly upstream of arp_cache and is the only master of its query port.
//  - Accepts IP lookup requests from the IP TX path.
//  - Selects the next hop: the destination itself, or the gateway when the destination is off-subnet.
//  - Queries the cache. On a miss it asks the ARP TX frame builder for a request, then waits and re-queries.
//  - Returns a MAC, or an error once the retries are exhausted. One lookup in flight at a time.
// PARAMETERS
//  REQUEST_RETRY_COUNT     4          ARP requests sent before giving up; 0 = error on first miss
//  REQUEST_RETRY_INTERVAL  250000000  clk cycles between an ARP request and the next cache re-query (>=1)
//  TIMER_WIDTH             32         retry timer width; must hold REQUEST_RETRY_INTERVAL
// PORTS
//  clk                         in   1   clock
//  rst_n                       in   1   asynchronous active-low reset
//  arp_request_valid           in   1   lookup request
//  arp_request_ready           out  1   lookup accepted when valid&ready
//  arp_request_ip              in   32  destination IP
//  arp_response_valid          out  1   lookup result
//  arp_response_ready          in   1   result consumed when valid&ready
//  arp_response_error          out  1   1 = unresolved
//  arp_response_mac            out  48  resolved MAC (0 on error)
//  cache_query_request_valid   out  1   to arp_cache query_request_valid
//  cache_query_request_ready   in   1   from arp_cache
//  cache_query_request_ip      out  32  next-hop IP
//  cache_query_response_valid  in   1   from arp_cache
//  cache_query_response_ready  out  1   to arp_cache
//  cache_query_response_error  in   1   1 = miss
//  cache_query_response_mac    in   48  cached MAC
//  arp_tx_req_valid            out  1   request to ARP TX frame builder
//  arp_tx_req_ready            in   1   frame builder accepted
//  arp_tx_req_ip               out  32  target protocol address
//  arp_rx_update_valid         in   1   1-cycle pulse: ARP RX wrote a cache entry
//  arp_rx_update_ip            in   32  IP written
//  local_ip, gateway_ip, subnet_mask  in  32 each  configuration, static while busy
//  busy                        out  1   high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, except arp_request_ready=1 from the first cycle after reset release. FSM=IDLE, retry counter=0, timer=0.
//  - All outputs are registered. Reset asserted mid-lookup aborts it; no response is ever issued for that lookup.
//  - IDLE: arp_request_ready=1.
//    - On accept: ready->0.
//    - Latch nh_ip = (((ip^local_ip)&subnet_mask)==0) ? ip : gateway_ip.
//    - Load retries=REQUEST_RETRY_COUNT. Go to QUERY.
//  - QUERY: cache_query_request_valid=1, ip=nh_ip, held until ready. On handshake go to WAIT_RESP.
//  - WAIT_RESP: cache_query_response_ready=1. On valid:
//    - error=0: latch MAC, go to RESPOND(ok).
//    - error=1, retries==0: go to RESPOND(error).
//    - error=1, retries>0: retries-=1, go to SEND_REQ.
//  - SEND_REQ: arp_tx_req_valid=1, ip=nh_ip, held until ready. On handshake: timer=REQUEST_RETRY_INTERVAL, go to WAIT_RETRY.
//  - WAIT_RETRY: timer decrements each cycle. Go to QUERY when timer reaches 1, or when arp_rx_update_valid && arp_rx_update_ip==nh_ip.
//    - An update and the timer expiring in the same cycle cause one transition only.
//    - Updates for other IPs are ignored. Updates in any other state are ignored.
//  - RESPOND: arp_response_valid=1 with error/mac stable until ready.
//    - On handshake return to IDLE. arp_request_ready is reasserted the following cycle, so lookups are never back-to-back.
//  - Hit latency (zero-wait cache, consumer always ready): request accept at cycle 0 -> arp_response_valid at cycle 4.
//  - Total ARP requests per failed lookup = REQUEST_RETRY_COUNT.
//  - Timer never wraps: it is loaded only in SEND_REQ and saturates at 0.
//  - subnet_mask=0 -> every IP is treated as on-subnet; no gateway is used.
// CONFIGURATION
//  ARP_RESOLVER_BCAST_EN
//  - Defined: on accept in IDLE, the lookup bypasses cache and ARP and goes straight to RESPOND(ok) with mac=48'hffffffffffff when either holds:
//    - ip==32'hffffffff
//    - ip is on-subnet and (ip|subnet_mask)==32'hffffffff (directed subnet broadcast)
//    - Response at cycle 1 after accept.
//  - Undefined: these IPs follow the normal cache/ARP path.
// TESTING
//  (REQUEST_RETRY_COUNT=2, REQUEST_RETRY_INTERVAL=16; local 192.168.1.10/24, gw 192.168.1.1)
//  - Hit: cache holds 192.168.1.20->02:00:00:00:00:20; request .20 -> query ip=.20; response error=0, mac=020000000020; no arp_tx_req.
//  - Off-subnet: request 10.0.0.5, cache holds .1 -> cache_query_request_ip=C0A80101, response carries the gateway MAC.
//  - Exhaustion: empty cache, request .30 -> 2 arp_tx_req (ip=C0A8011E) >=16 cycles apart, 3 queries, then error=1, mac=0.
//  - Early wake: miss, then rx_update ip=.30 at cycle 5 of WAIT_RETRY with entry written -> re-query next cycle, response ok, only 1 arp_tx_req.
//  - Back-pressure: hold arp_response_ready=0 for 10 cycles and arp_tx_req_ready=0 for 5 cycles -> valids and data stable, no lost or duplicate handshakes; assert rst_n low mid-WAIT_RETRY -> all outputs 0, arp_request_ready=1 after release.
//  - BCAST_EN: request 192.168.1.255 -> response cycle 1, mac=ffffffffffff, no cache query; without the macro -> cache query issued.

Source files
------------

// File: rtl/arp_resolver.sv
// arp_resolver
// ----------------------------------------------------------------------------
// Next-hop MAC resolver placed in front of arp_cache; it is the only master of
// the cache query port. Each lookup request picks a next hop (the destination
// when on-subnet, the gateway otherwise), queries the cache and returns the
// MAC. On a miss it asks the ARP TX frame builder to send a request, waits
// (or wakes early on a matching ARP RX cache update) and re-queries, until the
// retry budget is spent and an error response is returned.
// One lookup is in flight at a time; every output is registered.
//
// Optional feature (compile-time macro): ARP_RESOLVER_BCAST_EN
//   When defined, limited broadcast (255.255.255.255) and the directed subnet
//   broadcast are answered immediately with ff:ff:ff:ff:ff:ff, bypassing the
//   cache and ARP entirely.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   arp_request_*                  lookup request from the IP TX path (valid/ready, ip)
//   arp_response_*                 lookup result (valid/ready, error, mac)
//   cache_query_request_*          query to arp_cache (valid/ready, ip)
//   cache_query_response_*         answer from arp_cache (valid/ready, error, mac)
//   arp_tx_req_*                   ARP request to the TX frame builder (valid/ready, ip)
//   arp_rx_update_valid/_ip        one-cycle pulse: ARP RX wrote a cache entry
//   local_ip, gateway_ip, subnet_mask  static configuration while busy
//   busy                           high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module arp_resolver #(
    parameter int unsigned REQUEST_RETRY_COUNT    = 4,
    parameter int unsigned REQUEST_RETRY_INTERVAL = 250000000,
    parameter int unsigned TIMER_WIDTH            = 32
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        arp_request_valid,
    output logic        arp_request_ready,
    input  logic [31:0] arp_request_ip,

    output logic        arp_response_valid,
    input  logic        arp_response_ready,
    output logic        arp_response_error,
    output logic [47:0] arp_response_mac,

    output logic        cache_query_request_valid,
    input  logic        cache_query_request_ready,
    output logic [31:0] cache_query_request_ip,

    input  logic        cache_query_response_valid,
    output logic        cache_query_response_ready,
    input  logic        cache_query_response_error,
    input  logic [47:0] cache_query_response_mac,

    output logic        arp_tx_req_valid,
    input  logic        arp_tx_req_ready,
    output logic [31:0] arp_tx_req_ip,

    input  logic        arp_rx_update_valid,
    input  logic [31:0] arp_rx_update_ip,

    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask,

    output logic        busy
);

    // Retry counter must be at least one bit wide even when no retries are used.
    localparam int RETRY_WIDTH = (REQUEST_RETRY_COUNT < 1) ? 1 : $clog2(REQUEST_RETRY_COUNT + 1);
    localparam logic [RETRY_WIDTH-1:0] RETRY_INIT = RETRY_WIDTH'(REQUEST_RETRY_COUNT);
    localparam logic [TIMER_WIDTH-1:0] TIMER_INIT = TIMER_WIDTH'(REQUEST_RETRY_INTERVAL);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUERY,
        ST_WAIT_RESP,
        ST_SEND_REQ,
        ST_WAIT_RETRY,
        ST_RESPOND
    } state_t;

    state_t                 state_reg;
    logic [RETRY_WIDTH-1:0] retries_reg;
    logic [TIMER_WIDTH-1:0] timer_reg;
    logic [31:0]            nh_ip_reg;

    logic        arp_request_ready_reg;
    logic        arp_response_valid_reg;
    logic        arp_response_error_reg;
    logic [47:0] arp_response_mac_reg;
    logic        cache_query_request_valid_reg;
    logic        cache_query_response_ready_reg;
    logic        arp_tx_req_valid_reg;
    logic        busy_reg;

    // Next-hop selection for the incoming request.
    logic        on_subnet;
    logic [31:0] next_hop_ip;
    logic        wake_match;

    assign on_subnet   = ((arp_request_ip ^ local_ip) & subnet_mask) == 32'd0;
    assign next_hop_ip = on_subnet ? arp_request_ip : gateway_ip;
    assign wake_match  = arp_rx_update_valid && (arp_rx_update_ip == nh_ip_reg);

`ifdef ARP_RESOLVER_BCAST_EN
    logic is_bcast;
    assign is_bcast = (arp_request_ip == 32'hffff_ffff) ||
                      (on_subnet && ((arp_request_ip | subnet_mask) == 32'hffff_ffff));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg                      <= ST_IDLE;
            retries_reg                    <= '0;
            timer_reg                      <= '0;
            nh_ip_reg                      <= '0;
            arp_request_ready_reg          <= 1'b0;
            arp_response_valid_reg         <= 1'b0;
            arp_response_error_reg         <= 1'b0;
            arp_response_mac_reg           <= '0;
            cache_query_request_valid_reg  <= 1'b0;
            cache_query_response_ready_reg <= 1'b0;
            arp_tx_req_valid_reg           <= 1'b0;
            busy_reg                       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Ready comes up one cycle after reset release or after a
                    // response handshake, so lookups are never back-to-back.
                    if (!arp_request_ready_reg) begin
                        arp_request_ready_reg <= 1'b1;
                    end else if (arp_request_valid) begin
                        arp_request_ready_reg <= 1'b0;
                        busy_reg              <= 1'b1;
                        nh_ip_reg             <= next_hop_ip;
                        retries_reg           <= RETRY_INIT;
`ifdef ARP_RESOLVER_BCAST_EN
                        if (is_bcast) begin
                            arp_response_valid_reg <= 1'b1;
                            arp_response_error_reg <= 1'b0;
                            arp_response_mac_reg   <= 48'hffff_ffff_ffff;
                            state_reg              <= ST_RESPOND;
                        end else
`endif
                        begin
                            cache_query_request_valid_reg <= 1'b1;
                            state_reg                     <= ST_QUERY;
                        end
                    end
                end

                ST_QUERY: begin
                    if (cache_query_request_ready) begin
                        cache_query_request_valid_reg  <= 1'b0;
                        cache_query_response_ready_reg <= 1'b1;
                        state_reg                      <= ST_WAIT_RESP;
                    end
                end

                ST_WAIT_RESP: begin
                    if (cache_query_response_valid) begin
                        cache_query_response_ready_reg <= 1'b0;
                        if (!cache_query_response_error) begin
                            arp_response_valid_reg <= 1'b1;
                            arp_response_error_reg <= 1'b0;
                            arp_response_mac_reg   <= cache_query_response_mac;
                            state_reg              <= ST_RESPOND;
                        end else if (retries_reg == '0) begin
                            arp_response_valid_reg <= 1'b1;
                            arp_response_error_reg <= 1'b1;
                            arp_response_mac_reg   <= '0;
                            state_reg              <= ST_RESPOND;
                        end else begin
                            retries_reg          <= retries_reg - 1'b1;
                            arp_tx_req_valid_reg <= 1'b1;
                            state_reg            <= ST_SEND_REQ;
                        end
                    end
                end

                ST_SEND_REQ: begin
                    if (arp_tx_req_ready) begin
                        arp_tx_req_valid_reg <= 1'b0;
                        timer_reg            <= TIMER_INIT;
                        state_reg            <= ST_WAIT_RETRY;
                    end
                end

                ST_WAIT_RETRY: begin
                    // Expiry and a matching update in the same cycle share this
                    // single branch. Testing <=1 also covers a zero timer, so
                    // the state can never stall and the timer never wraps.
                    if (wake_match || (timer_reg <= TIMER_WIDTH'(1))) begin
                        timer_reg                     <= '0;
                        cache_query_request_valid_reg <= 1'b1;
                        state_reg                     <= ST_QUERY;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                ST_RESPOND: begin
                    if (arp_response_ready) begin
                        arp_response_valid_reg <= 1'b0;
                        arp_response_error_reg <= 1'b0;
                        arp_response_mac_reg   <= '0;
                        busy_reg               <= 1'b0;
                        state_reg              <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign arp_request_ready          = arp_request_ready_reg;
    assign arp_response_valid         = arp_response_valid_reg;
    assign arp_response_error         = arp_response_error_reg;
    assign arp_response_mac           = arp_response_mac_reg;
    assign cache_query_request_valid  = cache_query_request_valid_reg;
    assign cache_query_request_ip     = nh_ip_reg;
    assign cache_query_response_ready = cache_query_response_ready_reg;
    assign arp_tx_req_valid           = arp_tx_req_valid_reg;
    assign arp_tx_req_ip              = nh_ip_reg;
    assign busy                       = busy_reg;

endmodule

// File: tb/tb_arp_resolver.sv
// tb_arp_resolver
// Directed bench for arp_resolver with REQUEST_RETRY_COUNT=2 and
// REQUEST_RETRY_INTERVAL=16; local 192.168.1.10/24, gateway 192.168.1.1.
// A small behavioural arp_cache answers queries: a query accepted at edge h
// is looked up at edge h+1 and its response is presented from edge h+1 on,
// held until the resolver takes it.
module tb_arp_resolver;
    localparam int RC = 2;
    localparam int RI = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        arp_request_valid;
    logic        arp_request_ready;
    logic [31:0] arp_request_ip;
    logic        arp_response_valid;
    logic        arp_response_ready;
    logic        arp_response_error;
    logic [47:0] arp_response_mac;
    logic        cache_query_request_valid;
    logic        cache_query_request_ready;
    logic [31:0] cache_query_request_ip;
    logic        cache_query_response_valid;
    logic        cache_query_response_ready;
    logic        cache_query_response_error;
    logic [47:0] cache_query_response_mac;
    logic        arp_tx_req_valid;
    logic        arp_tx_req_ready;
    logic [31:0] arp_tx_req_ip;
    logic        arp_rx_update_valid;
    logic [31:0] arp_rx_update_ip;
    logic [31:0] local_ip;
    logic [31:0] gateway_ip;
    logic [31:0] subnet_mask;
    logic        busy;

    arp_resolver #(
        .REQUEST_RETRY_COUNT   (RC),
        .REQUEST_RETRY_INTERVAL(RI),
        .TIMER_WIDTH           (32)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .arp_request_valid          (arp_request_valid),
        .arp_request_ready          (arp_request_ready),
        .arp_request_ip             (arp_request_ip),
        .arp_response_valid         (arp_response_valid),
        .arp_response_ready         (arp_response_ready),
        .arp_response_error         (arp_response_error),
        .arp_response_mac           (arp_response_mac),
        .cache_query_request_valid  (cache_query_request_valid),
        .cache_query_request_ready  (cache_query_request_ready),
        .cache_query_request_ip     (cache_query_request_ip),
        .cache_query_response_valid (cache_query_response_valid),
        .cache_query_response_ready (cache_query_response_ready),
        .cache_query_response_error (cache_query_response_error),
        .cache_query_response_mac   (cache_query_response_mac),
        .arp_tx_req_valid           (arp_tx_req_valid),
        .arp_tx_req_ready           (arp_tx_req_ready),
        .arp_tx_req_ip              (arp_tx_req_ip),
        .arp_rx_update_valid        (arp_rx_update_valid),
        .arp_rx_update_ip           (arp_rx_update_ip),
        .local_ip                   (local_ip),
        .gateway_ip                 (gateway_ip),
        .subnet_mask                (subnet_mask),
        .busy                       (busy)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural cache ----------------
    logic [31:0] c_ip  [4];
    logic [47:0] c_mac [4];
    logic        c_vld [4];
    logic        cq_pend;
    logic [31:0] cq_pend_ip;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cq_pend                    <= 1'b0;
            cache_query_response_valid <= 1'b0;
            cache_query_response_error <= 1'b0;
            cache_query_response_mac   <= '0;
        end else begin
            if (cache_query_response_valid && cache_query_response_ready)
                cache_query_response_valid <= 1'b0;
            if (cq_pend) begin
                cq_pend                    <= 1'b0;
                cache_query_response_valid <= 1'b1;
                cache_query_response_error <= 1'b1;
                cache_query_response_mac   <= '0;
                for (int i = 0; i < 4; i++) begin
                    if (c_vld[i] && c_ip[i] == cq_pend_ip) begin
                        cache_query_response_error <= 1'b0;
                        cache_query_response_mac   <= c_mac[i];
                    end
                end
            end
            if (cache_query_request_valid && cache_query_request_ready) begin
                cq_pend    <= 1'b1;
                cq_pend_ip <= cache_query_request_ip;
            end
        end
    end

    // ---------------- handshake monitors ----------------
    int          cyc = 0;
    int          q_count = 0;
    int          tx_count = 0;
    int          resp_count = 0;
    int          last_tx_cyc = 0;
    int          prev_tx_cyc = 0;
    logic [31:0] last_q_ip = '0;
    logic [31:0] last_tx_ip = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (cache_query_request_valid && cache_query_request_ready) begin
                q_count   <= q_count + 1;
                last_q_ip <= cache_query_request_ip;
            end
            if (arp_tx_req_valid && arp_tx_req_ready) begin
                tx_count    <= tx_count + 1;
                last_tx_ip  <= arp_tx_req_ip;
                prev_tx_cyc <= last_tx_cyc;
                last_tx_cyc <= cyc;
            end
            if (arp_response_valid && arp_response_ready)
                resp_count <= resp_count + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [31:0] ip);
        int n;
        n = 0;
        while (!arp_request_ready && n < 50) begin
            tick();
            n++;
        end
        arp_request_valid = 1'b1;
        arp_request_ip    = ip;
        tick();
        arp_request_valid = 1'b0;
    endtask

    // Waits for the response; lat is the cycle count from the accept edge.
    task automatic wait_resp(output logic err, output logic [47:0] mac, output int lat);
        lat = 1;
        while (!arp_response_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk("resp_arrives", arp_response_valid, 1'b1);
        err = arp_response_error;
        mac = arp_response_mac;
    endtask

    task automatic lookup(input logic [31:0] ip, output logic err, output logic [47:0] mac, output int lat);
        start_req(ip);
        wait_resp(err, mac, lat);
        if (arp_response_ready) tick();
    endtask

    // ---------------- directed sequence ----------------
    logic        err;
    logic [47:0] mac;
    logic [47:0] cap_mac;
    logic [31:0] cap_ip;
    int          lat;
    int          q0, t0, r0, n;
    logic        stable;

    initial begin
        arp_request_valid   = 1'b0;
        arp_request_ip      = '0;
        arp_response_ready  = 1'b1;
        cache_query_request_ready = 1'b1;
        arp_tx_req_ready    = 1'b1;
        arp_rx_update_valid = 1'b0;
        arp_rx_update_ip    = '0;
        local_ip    = 32'hC0A8010A;
        gateway_ip  = 32'hC0A80101;
        subnet_mask = 32'hFFFFFF00;
        c_ip[0] = 32'hC0A80114; c_mac[0] = 48'h020000000020; c_vld[0] = 1'b1;
        c_ip[1] = 32'hC0A80101; c_mac[1] = 48'h020000000001; c_vld[1] = 1'b1;
        c_ip[2] = '0;           c_mac[2] = '0;               c_vld[2] = 1'b0;
        c_ip[3] = '0;           c_mac[3] = '0;               c_vld[3] = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset_ctl", {arp_request_ready, arp_response_valid, cache_query_request_valid,
                          cache_query_response_ready, arp_tx_req_valid, busy}, 6'b0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", arp_request_ready, 1'b1);

        // Cache hit, on-subnet
        q0 = q_count; t0 = tx_count;
        lookup(32'hC0A80114, err, mac, lat);
        $display("hit: err=%0d mac=%012h lat=%0d", err, mac, lat);
        chk("hit_err", err, 1'b0);
        chk("hit_mac", mac, 48'h020000000020);
        chk("hit_latency", lat, 4);
        chk("hit_query_ip", last_q_ip, 32'hC0A80114);
        chk("hit_queries", q_count - q0, 1);
        chk("hit_no_tx", tx_count - t0, 0);
        chk("idle_ready_gap", arp_request_ready, 1'b0);
        chk("idle_busy", busy, 1'b0);
        tick();
        chk("idle_ready_back", arp_request_ready, 1'b1);

        // Off-subnet goes via gateway
        lookup(32'h0A000005, err, mac, lat);
        $display("offsubnet: err=%0d mac=%012h qip=%08h", err, mac, last_q_ip);
        chk("gw_query_ip", last_q_ip, 32'hC0A80101);
        chk("gw_mac", mac, 48'h020000000001);
        chk("gw_err", err, 1'b0);

        // Retry exhaustion
        q0 = q_count; t0 = tx_count;
        lookup(32'hC0A8011E, err, mac, lat);
        $display("exhaust: err=%0d mac=%012h tx=%0d q=%0d", err, mac, tx_count - t0, q_count - q0);
        chk("exh_err", err, 1'b1);
        chk("exh_mac", mac, 48'h0);
        chk("exh_tx_count", tx_count - t0, RC);
        chk("exh_queries", q_count - q0, RC + 1);
        chk("exh_tx_ip", last_tx_ip, 32'hC0A8011E);
        chk("exh_tx_spacing", (last_tx_cyc - prev_tx_cyc) >= RI, 1'b1);

        // Early wake on matching rx update; foreign update ignored
        q0 = q_count; t0 = tx_count;
        start_req(32'hC0A8011E);
        n = 0;
        while (tx_count == t0 && n < 50) begin
            tick();
            n++;
        end
        chk("wake_tx_seen", tx_count - t0, 1);
        tick();                                   // WAIT_RETRY cycle 2
        arp_rx_update_valid = 1'b1;
        arp_rx_update_ip    = 32'hC0A80163;
        tick();
        arp_rx_update_valid = 1'b0;
        chk("wake_foreign_ignored", cache_query_request_valid, 1'b0);
        tick();
        tick();                                   // WAIT_RETRY cycle 5
        c_ip[2] = 32'hC0A8011E; c_mac[2] = 48'h020000000030; c_vld[2] = 1'b1;
        arp_rx_update_valid = 1'b1;
        arp_rx_update_ip    = 32'hC0A8011E;
        tick();
        arp_rx_update_valid = 1'b0;
        chk("wake_requery", cache_query_request_valid, 1'b1);
        wait_resp(err, mac, lat);
        tick();
        $display("wake: err=%0d mac=%012h tx=%0d", err, mac, tx_count - t0);
        chk("wake_err", err, 1'b0);
        chk("wake_mac", mac, 48'h020000000030);
        chk("wake_tx_total", tx_count - t0, 1);
        c_vld[2] = 1'b0;

        // Response back-pressure
        arp_response_ready = 1'b0;
        start_req(32'hC0A80114);
        wait_resp(err, cap_mac, lat);
        r0 = resp_count;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (!(arp_response_valid && arp_response_mac == cap_mac && !arp_response_error))
                stable = 1'b0;
        end
        $display("resp_bp: mac=%012h stable=%0d", cap_mac, stable);
        chk("resp_bp_stable", stable, 1'b1);
        chk("resp_bp_no_hs", resp_count - r0, 0);
        arp_response_ready = 1'b1;
        tick();
        chk("resp_bp_drop", arp_response_valid, 1'b0);
        chk("resp_bp_one_hs", resp_count - r0, 1);

        // TX back-pressure, then reset mid WAIT_RETRY
        arp_tx_req_ready = 1'b0;
        t0 = tx_count;
        start_req(32'hC0A8011E);
        n = 0;
        while (!arp_tx_req_valid && n < 50) begin
            tick();
            n++;
        end
        chk("tx_bp_valid", arp_tx_req_valid, 1'b1);
        cap_ip = arp_tx_req_ip;
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (!(arp_tx_req_valid && arp_tx_req_ip == 32'hC0A8011E)) stable = 1'b0;
        end
        $display("tx_bp: ip=%08h stable=%0d", cap_ip, stable);
        chk("tx_bp_stable", stable, 1'b1);
        chk("tx_bp_no_hs", tx_count - t0, 0);
        arp_tx_req_ready = 1'b1;
        tick();
        chk("tx_bp_drop", arp_tx_req_valid, 1'b0);
        chk("tx_bp_one_hs", tx_count - t0, 1);
        repeat (3) tick();
        r0 = resp_count;
        rst_n = 1'b0;
        #1;
        chk("midrst_ctl", {arp_request_ready, arp_response_valid, arp_response_error,
                           cache_query_request_valid, cache_query_response_ready,
                           arp_tx_req_valid, busy}, 7'b0);
        chk("midrst_mac", arp_response_mac, 48'h0);
        chk("midrst_ips", {cache_query_request_ip, arp_tx_req_ip}, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_ready", arp_request_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        stable = 1'b1;
        repeat (30) begin
            tick();
            if (arp_response_valid || cache_query_request_valid || arp_tx_req_valid) stable = 1'b0;
        end
        chk("midrst_quiet", stable, 1'b1);
        chk("midrst_no_resp", resp_count - r0, 0);

        // subnet_mask=0: everything on-subnet
        subnet_mask = 32'h0;
        c_ip[3] = 32'h0A000005; c_mac[3] = 48'h020000000005; c_vld[3] = 1'b1;
        lookup(32'h0A000005, err, mac, lat);
        $display("mask0: qip=%08h mac=%012h", last_q_ip, mac);
        chk("mask0_query_ip", last_q_ip, 32'h0A000005);
        chk("mask0_mac", mac, 48'h020000000005);
        subnet_mask = 32'hFFFFFF00;

        // Directed subnet broadcast
        q0 = q_count;
        lookup(32'hC0A801FF, err, mac, lat);
        $display("bcast: err=%0d mac=%012h lat=%0d q=%0d", err, mac, lat, q_count - q0);
`ifdef ARP_RESOLVER_BCAST_EN
        chk("bcast_latency", lat, 1);
        chk("bcast_mac", mac, 48'hFFFFFFFFFFFF);
        chk("bcast_err", err, 1'b0);
        chk("bcast_no_query", q_count - q0, 0);
`else
        chk("bcast_queries", q_count - q0, RC + 1);
        chk("bcast_query_ip", last_q_ip, 32'hC0A801FF);
        chk("bcast_err", err, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
